quiz_round_controller: RTL and testbench
========================================

# quiz_round_controller

Host-side round sequencer for the fastest-finger-first buzzer arbiter. It opens a round by releasing the arbiter from reset and times the buzz-in window. It consumes the arbiter's winner flags, times the winner's answer, applies the judge's verdict to per-user saturating scores, then re-arms the arbiter for the next round. It sits between the host/judge panel and the arbiter, and drives the arbiter's active-high reset.

## Interface
Parameters:
- ARM_CYCLES, 1000: buzz-in window length in clk cycles (>=1)
- ANSWER_CYCLES, 500: answer window length in clk cycles (>=1)
- RESULT_CYCLES, 100: result display hold in clk cycles (>=1)
- SCORE_W, 8: score register width

Ports:
- clk  in  1  system clock, all logic on rising edge
- rst_n  in  1  asynchronous, active-low reset
- start  in  1  host request to open a round (sampled each cycle)
- clear_scores  in  1  zero both scores (honoured in IDLE only)
- winner_user1  in  1  arbiter winner flag, user 1
- winner_user2  in  1  arbiter winner flag, user 2
- judge_correct  in  1  judge verdict pulse: correct
- judge_wrong  in  1  judge verdict pulse: wrong
- arb_rst  out  1  active-high reset to the arbiter
- armed  out  1  high in ARMED
- answering  out  1  high in ANSWER
- active_user  out  2  01 = user1, 10 = user2, 00 = none
- timeout  out  1  latched: last round ended by a timer expiry
- timer  out  16  remaining cycles of the current window, minus 1 (0 outside ARMED/ANSWER)
- score1, score2  out  SCORE_W  user scores
- round_count  out  8  completed rounds, wraps 255->0
- round_done  out  1  one-cycle pulse on RESULT->IDLE

## Operation
- Reset values: state IDLE, arb_rst=1, armed=0, answering=0, active_user=00, timeout=0, timer=0, scores=0, round_count=0, round_done=0.
- IDLE:
  - arb_rst=1.
  - clear_scores zeroes both scores.
  - start -> ARMED; timer loads ARM_CYCLES-1, timeout clears, active_user clears.
  - clear_scores and start in the same cycle: both take effect.
- ARMED:
  - arb_rst=0; timer decrements each cycle.
  - Exactly one winner flag high -> ANSWER; active_user latches that user; timer loads ANSWER_CYCLES-1.
  - Both flags high in the same cycle -> void round -> RESULT, active_user=00, no score change.
  - No winner and timer==0 -> RESULT with timeout=1.
  - A winner flag takes priority over expiry in the same cycle.
- ANSWER:
  - arb_rst=0, which holds the arbiter's lockout; timer decrements each cycle.
  - judge_correct -> active user's score +1, saturating at 2^SCORE_W-1.
  - judge_wrong -> active user's score -1, saturating at 0.
  - judge_wrong and judge_correct together are treated as wrong.
  - No verdict and timer==0 -> treated as wrong, timeout=1.
  - A verdict takes priority over expiry in the same cycle.
  - Every exit goes to RESULT with timer loaded to RESULT_CYCLES-1.
- RESULT:
  - arb_rst=1; active_user and timeout are held for display.
  - Timer decrements; at timer==0 -> IDLE, round_done pulses, round_count increments.
- Inputs that are illegal for the current state are ignored: start outside IDLE, verdicts outside ANSWER, winner flags outside ARMED.
- Asynchronous reset mid-round returns the block to reset values immediately and asserts arb_rst.

## Timing
- All outputs are registered; state changes take effect on the edge after the triggering input is sampled.
- start sampled at edge N -> armed=1 and arb_rst=0 from edge N+1.
- ARMED lasts exactly ARM_CYCLES cycles if no winner arrives.
- ANSWER lasts at most ANSWER_CYCLES cycles.
- RESULT lasts exactly RESULT_CYCLES cycles.
- Score update is visible in the first RESULT cycle.
- round_done is high for exactly one cycle, concurrent with the first IDLE cycle.
- The timer field is 16 bits; parameters must be <= 65536.

## Test plan
All scenarios use ARM_CYCLES=8, ANSWER_CYCLES=4, RESULT_CYCLES=2, SCORE_W=4.
- Reset, then start pulse -> arb_rst falls the next cycle; armed=1 with timer=7; no winner -> after 8 cycles RESULT with timeout=1, scores 0/0, then round_done pulse and round_count=1.
- winner_user1 in the 3rd ARMED cycle, judge_correct 2 cycles later -> active_user=01, score1=1, score2=0, timeout=0, arb_rst=1 in RESULT.
- winner_user2, no verdict -> ANSWER ends after 4 cycles with timeout=1; score2 stays 0 (saturate); then winner_user2 + correct twice and wrong once -> score2=1.
- Both winner flags high in the same cycle -> active_user=00, no score change, RESULT entered.
- Score1 preloaded to 15 through repeated rounds, then another correct -> remains 15; judge_correct+judge_wrong together -> score1=14.
- rst_n low in ANSWER -> all outputs at reset values asynchronously; clear_scores pulsed during ARMED -> ignored; clear_scores pulsed in IDLE -> scores 0.

Source files
------------

// File: rtl/quiz_round_controller.sv
// Round sequencer for the buzzer arbiter: opens the buzz-in window, times the
// winner's answer, applies the judge's verdict to saturating scores, re-arms.
module quiz_round_controller #(
    parameter int ARM_CYCLES    = 1000,
    parameter int ANSWER_CYCLES = 500,
    parameter int RESULT_CYCLES = 100,
    parameter int SCORE_W       = 8
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start,
    input  logic               clear_scores,
    input  logic               winner_user1,
    input  logic               winner_user2,
    input  logic               judge_correct,
    input  logic               judge_wrong,
    output logic               arb_rst,
    output logic               armed,
    output logic               answering,
    output logic [1:0]         active_user,
    output logic               timeout,
    output logic [15:0]        timer,
    output logic [SCORE_W-1:0] score1,
    output logic [SCORE_W-1:0] score2,
    output logic [7:0]         round_count,
    output logic               round_done
);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_ARMED  = 2'd1,
        S_ANSWER = 2'd2,
        S_RESULT = 2'd3
    } state_t;

    localparam logic [15:0]        ARM_LOAD  = 16'(ARM_CYCLES - 1);
    localparam logic [15:0]        ANS_LOAD  = 16'(ANSWER_CYCLES - 1);
    localparam logic [15:0]        RES_LOAD  = 16'(RESULT_CYCLES - 1);
    localparam logic [SCORE_W-1:0] SCORE_MAX = {SCORE_W{1'b1}};

    function automatic logic [SCORE_W-1:0] sat_inc(input logic [SCORE_W-1:0] v);
        return (v == SCORE_MAX) ? v : v + 1'b1;
    endfunction

    function automatic logic [SCORE_W-1:0] sat_dec(input logic [SCORE_W-1:0] v);
        return (v == '0) ? v : v - 1'b1;
    endfunction

    state_t             r_state,  w_state_nx;
    logic [15:0]        r_timer,  w_timer_nx;
    logic [15:0]        r_timer_out, w_timer_out_nx;
    logic [1:0]         r_active, w_active_nx;
    logic               r_timeout, w_timeout_nx;
    logic [SCORE_W-1:0] r_score1, w_score1_nx;
    logic [SCORE_W-1:0] r_score2, w_score2_nx;
    logic [7:0]         r_count,  w_count_nx;
    logic               r_done,   w_done_nx;
    logic               r_arb_rst, w_arb_rst_nx;
    logic               r_armed,  w_armed_nx;
    logic               r_answering, w_answering_nx;
    logic               w_reward;

    always_comb begin
        w_state_nx   = r_state;
        w_timer_nx   = r_timer;
        w_active_nx  = r_active;
        w_timeout_nx = r_timeout;
        w_score1_nx  = r_score1;
        w_score2_nx  = r_score2;
        w_count_nx   = r_count;
        w_done_nx    = 1'b0;
        // A simultaneous correct+wrong counts as wrong
        w_reward     = judge_correct && !judge_wrong;

        case (r_state)
            S_IDLE: begin
                if (clear_scores) begin
                    w_score1_nx = '0;
                    w_score2_nx = '0;
                end
                if (start) begin
                    w_state_nx   = S_ARMED;
                    w_timer_nx   = ARM_LOAD;
                    w_timeout_nx = 1'b0;
                    w_active_nx  = 2'b00;
                end
            end
            S_ARMED: begin
                if (winner_user1 && winner_user2) begin
                    w_state_nx  = S_RESULT;
                    w_active_nx = 2'b00;
                    w_timer_nx  = RES_LOAD;
                end else if (winner_user1 || winner_user2) begin
                    w_state_nx  = S_ANSWER;
                    w_active_nx = {winner_user2, winner_user1};
                    w_timer_nx  = ANS_LOAD;
                end else if (r_timer == 16'd0) begin
                    w_state_nx   = S_RESULT;
                    w_timeout_nx = 1'b1;
                    w_timer_nx   = RES_LOAD;
                end else begin
                    w_timer_nx = r_timer - 16'd1;
                end
            end
            S_ANSWER: begin
                if (judge_correct || judge_wrong || r_timer == 16'd0) begin
                    w_state_nx   = S_RESULT;
                    w_timer_nx   = RES_LOAD;
                    w_timeout_nx = !(judge_correct || judge_wrong);
                    if (r_active[0])
                        w_score1_nx = w_reward ? sat_inc(r_score1) : sat_dec(r_score1);
                    if (r_active[1])
                        w_score2_nx = w_reward ? sat_inc(r_score2) : sat_dec(r_score2);
                end else begin
                    w_timer_nx = r_timer - 16'd1;
                end
            end
            S_RESULT: begin
                if (r_timer == 16'd0) begin
                    w_state_nx = S_IDLE;
                    w_timer_nx = 16'd0;
                    w_count_nx = r_count + 8'd1;
                    w_done_nx  = 1'b1;
                end else begin
                    w_timer_nx = r_timer - 16'd1;
                end
            end
            default: w_state_nx = S_IDLE;
        endcase

        w_arb_rst_nx    = (w_state_nx == S_IDLE) || (w_state_nx == S_RESULT);
        w_armed_nx      = (w_state_nx == S_ARMED);
        w_answering_nx  = (w_state_nx == S_ANSWER);
        // RESULT keeps counting internally but shows 0 on the output
        w_timer_out_nx  = (w_armed_nx || w_answering_nx) ? w_timer_nx : 16'd0;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= S_IDLE;
            r_timer     <= 16'd0;
            r_timer_out <= 16'd0;
            r_active    <= 2'b00;
            r_timeout   <= 1'b0;
            r_score1    <= '0;
            r_score2    <= '0;
            r_count     <= 8'd0;
            r_done      <= 1'b0;
            r_arb_rst   <= 1'b1;
            r_armed     <= 1'b0;
            r_answering <= 1'b0;
        end else begin
            r_state     <= w_state_nx;
            r_timer     <= w_timer_nx;
            r_timer_out <= w_timer_out_nx;
            r_active    <= w_active_nx;
            r_timeout   <= w_timeout_nx;
            r_score1    <= w_score1_nx;
            r_score2    <= w_score2_nx;
            r_count     <= w_count_nx;
            r_done      <= w_done_nx;
            r_arb_rst   <= w_arb_rst_nx;
            r_armed     <= w_armed_nx;
            r_answering <= w_answering_nx;
        end
    end

    assign arb_rst     = r_arb_rst;
    assign armed       = r_armed;
    assign answering   = r_answering;
    assign active_user = r_active;
    assign timeout     = r_timeout;
    assign timer       = r_timer_out;
    assign score1      = r_score1;
    assign score2      = r_score2;
    assign round_count = r_count;
    assign round_done  = r_done;

endmodule

// File: tb/tb_quiz_round_controller.sv
// Directed bench for quiz_round_controller (ARM=8, ANSWER=4, RESULT=2, SCORE_W=4).
module tb_quiz_round_controller;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start, clear_scores, winner_user1, winner_user2;
    logic        judge_correct, judge_wrong;
    logic        arb_rst, armed, answering, timeout, round_done;
    logic [1:0]  active_user;
    logic [15:0] timer;
    logic [3:0]  score1, score2;
    logic [7:0]  round_count;

    int n_pass  = 0;
    int n_total = 0;

    quiz_round_controller #(
        .ARM_CYCLES(8), .ANSWER_CYCLES(4), .RESULT_CYCLES(2), .SCORE_W(4)
    ) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .clear_scores(clear_scores),
        .winner_user1(winner_user1), .winner_user2(winner_user2),
        .judge_correct(judge_correct), .judge_wrong(judge_wrong),
        .arb_rst(arb_rst), .armed(armed), .answering(answering),
        .active_user(active_user), .timeout(timeout), .timer(timer),
        .score1(score1), .score2(score2), .round_count(round_count),
        .round_done(round_done)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    task automatic tick(input int n = 1);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Leaves the bench in the first RESULT cycle
    task automatic answer_round(input logic w1, input logic w2, input logic jc, input logic jw);
        start = 1'b1;
        tick();
        start = 1'b0;
        winner_user1 = w1;
        winner_user2 = w2;
        tick();
        winner_user1 = 1'b0;
        winner_user2 = 1'b0;
        judge_correct = jc;
        judge_wrong   = jw;
        tick();
        judge_correct = 1'b0;
        judge_wrong   = 1'b0;
    endtask

    // From the first RESULT cycle to the first IDLE cycle
    task automatic finish_round();
        tick(2);
    endtask

    initial begin
        rst_n = 1'b0;
        start = 1'b0; clear_scores = 1'b0;
        winner_user1 = 1'b0; winner_user2 = 1'b0;
        judge_correct = 1'b0; judge_wrong = 1'b0;
        tick(2);
        chk("rst_arb_rst", 32'(arb_rst), 32'd1);
        chk("rst_armed", 32'(armed), 32'd0);
        chk("rst_timer", 32'(timer), 32'd0);
        chk("rst_scores", {24'd0, score1, score2}, 32'h00);
        chk("rst_count", 32'(round_count), 32'd0);
        chk("rst_done", 32'(round_done), 32'd0);
        rst_n = 1'b1;
        tick();

        // Round 1: no winner, window expires
        start = 1'b1;
        tick();
        start = 1'b0;
        chk("r1_armed", 32'(armed), 32'd1);
        chk("r1_arb_rst_low", 32'(arb_rst), 32'd0);
        chk("r1_timer7", 32'(timer), 32'd7);
        tick(7);
        chk("r1_last_armed", {31'd0, armed}, 32'd1);
        chk("r1_timer0", 32'(timer), 32'd0);
        tick();
        chk("r1_result_armed", 32'(armed), 32'd0);
        chk("r1_timeout", 32'(timeout), 32'd1);
        chk("r1_result_arb_rst", 32'(arb_rst), 32'd1);
        chk("r1_scores", {24'd0, score1, score2}, 32'h00);
        tick();
        chk("r1_done_early", 32'(round_done), 32'd0);
        tick();
        chk("r1_done", 32'(round_done), 32'd1);
        chk("r1_count", 32'(round_count), 32'd1);
        tick();
        chk("r1_done_pulse", 32'(round_done), 32'd0);

        // Round 2: user1 buzzes in 3rd ARMED cycle, correct
        start = 1'b1;
        tick();
        start = 1'b0;
        tick(2);
        winner_user1 = 1'b1;
        tick();
        winner_user1 = 1'b0;
        chk("r2_answering", 32'(answering), 32'd1);
        chk("r2_active", 32'(active_user), 32'd1);
        chk("r2_timer3", 32'(timer), 32'd3);
        tick();
        judge_correct = 1'b1;
        tick();
        judge_correct = 1'b0;
        chk("r2_scores", {24'd0, score1, score2}, 32'h10);
        chk("r2_timeout", 32'(timeout), 32'd0);
        chk("r2_arb_rst", 32'(arb_rst), 32'd1);
        chk("r2_active_hold", 32'(active_user), 32'd1);
        finish_round();
        chk("r2_count", 32'(round_count), 32'd2);

        // Round 3: user2 buzzes, no verdict
        start = 1'b1;
        tick();
        start = 1'b0;
        winner_user2 = 1'b1;
        tick();
        winner_user2 = 1'b0;
        chk("r3_active", 32'(active_user), 32'd2);
        tick(3);
        chk("r3_last_answer", 32'(answering), 32'd1);
        tick();
        chk("r3_answer_end", 32'(answering), 32'd0);
        chk("r3_timeout", 32'(timeout), 32'd1);
        chk("r3_score2_sat0", 32'(score2), 32'd0);
        finish_round();

        answer_round(1'b0, 1'b1, 1'b1, 1'b0);
        chk("r4_score2", 32'(score2), 32'd1);
        finish_round();
        answer_round(1'b0, 1'b1, 1'b1, 1'b0);
        chk("r5_score2", 32'(score2), 32'd2);
        finish_round();
        answer_round(1'b0, 1'b1, 1'b0, 1'b1);
        chk("r6_score2", 32'(score2), 32'd1);
        chk("r6_score1", 32'(score1), 32'd1);
        finish_round();
        chk("r6_count", 32'(round_count), 32'd6);

        // Round 7: both flags together voids the round
        start = 1'b1;
        tick();
        start = 1'b0;
        winner_user1 = 1'b1;
        winner_user2 = 1'b1;
        tick();
        winner_user1 = 1'b0;
        winner_user2 = 1'b0;
        chk("r7_active", 32'(active_user), 32'd0);
        chk("r7_answering", 32'(answering), 32'd0);
        chk("r7_arb_rst", 32'(arb_rst), 32'd1);
        chk("r7_scores", {24'd0, score1, score2}, 32'h11);
        finish_round();
        chk("r7_done", 32'(round_done), 32'd1);

        // Drive score1 to saturation
        for (int k = 0; k < 14; k++) begin
            answer_round(1'b1, 1'b0, 1'b1, 1'b0);
            finish_round();
        end
        chk("sat_score1_15", 32'(score1), 32'd15);
        answer_round(1'b1, 1'b0, 1'b1, 1'b0);
        chk("sat_hold_15", 32'(score1), 32'd15);
        finish_round();
        answer_round(1'b1, 1'b0, 1'b1, 1'b1);
        chk("both_verdicts_wrong", 32'(score1), 32'd14);
        chk("both_verdicts_timeout", 32'(timeout), 32'd0);
        finish_round();
        chk("count_23", 32'(round_count), 32'd23);

        // Async reset in ANSWER
        start = 1'b1;
        tick();
        start = 1'b0;
        winner_user1 = 1'b1;
        tick();
        winner_user1 = 1'b0;
        chk("pre_rst_answering", 32'(answering), 32'd1);
        #2 rst_n = 1'b0;
        #1;
        chk("arst_answering", 32'(answering), 32'd0);
        chk("arst_arb_rst", 32'(arb_rst), 32'd1);
        chk("arst_active", 32'(active_user), 32'd0);
        chk("arst_scores", {24'd0, score1, score2}, 32'h00);
        chk("arst_count", 32'(round_count), 32'd0);
        tick();
        rst_n = 1'b1;
        tick();

        answer_round(1'b1, 1'b0, 1'b1, 1'b0);
        finish_round();
        chk("post_rst_score1", 32'(score1), 32'd1);

        // clear_scores ignored in ARMED
        start = 1'b1;
        tick();
        start = 1'b0;
        clear_scores = 1'b1;
        tick();
        clear_scores = 1'b0;
        chk("clear_in_armed", 32'(score1), 32'd1);
        tick(7);
        chk("clr_round_timeout", 32'(timeout), 32'd1);
        finish_round();
        clear_scores = 1'b1;
        tick();
        clear_scores = 1'b0;
        chk("clear_in_idle", {24'd0, score1, score2}, 32'h00);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
